// File: rtl/gd_train_sequencer.sv
// Control sequencer for the gradient-descent core: deserialises the training set into
// data memory, then walks epochs x points. Optional watchdog: define GD_SEQ_WDOG_EN.
module gd_train_sequencer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int LENGTH      = 16,
  parameter int FEAT_BITS   = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  S,
  input  logic [FEAT_BITS-1:0]  feat,
  input  logic [ADDR_WIDTH-1:0] data_points,
  input  logic [7:0]            epoch,
  input  logic [3:0]            learn_rate,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_row,
  output logic [FEAT_BITS-1:0]  mem_col,
  output logic [LENGTH-1:0]     mem_wdata,
  output logic                  mem_re,
  output logic                  upd_start,
  input  logic                  upd_done,
  output logic [3:0]            lr_q,
  output logic [FEAT_BITS-1:0]  feat_q,
  output logic [7:0]            cur_epoch,
  output logic                  done_,
  output logic                  err
);

  localparam int BW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(LENGTH - 1);

  // WLAST is the write cycle of the final word; loading is over but mem_we is still up.
  typedef enum logic [2:0] {LOAD, WLAST, RD, ST, WT, DONE} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [LENGTH-1:0]     sh_q, sh_d;
  logic [FEAT_BITS-1:0]  wcol_q, wcol_d;
  logic [ADDR_WIDTH-1:0] wrow_q, wrow_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [FEAT_BITS-1:0]  col_q, col_d;
  logic [LENGTH-1:0]     wdata_q, wdata_d;
  logic [7:0]            cur_q, cur_d;
  logic [FEAT_BITS-1:0]  cfg_feat_q;
  logic [ADDR_WIDTH-1:0] cfg_dp_q;
  logic [7:0]            cfg_ep_q;
  logic [3:0]            cfg_lr_q;

`ifdef GD_SEQ_WDOG_EN
  localparam int WDW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(WDOG_CYCLES - 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= LOAD;
      bit_q      <= '0;
      sh_q       <= '0;
      wcol_q     <= feat;
      wrow_q     <= '0;
      we_q       <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      wdata_q    <= '0;
      cur_q      <= '0;
      cfg_feat_q <= feat;
      cfg_dp_q   <= data_points;
      cfg_ep_q   <= epoch;
      cfg_lr_q   <= learn_rate;
`ifdef GD_SEQ_WDOG_EN
      wd_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      wcol_q  <= wcol_d;
      wrow_q  <= wrow_d;
      we_q    <= we_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wdata_q <= wdata_d;
      cur_q   <= cur_d;
`ifdef GD_SEQ_WDOG_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    wcol_d  = wcol_q;
    wrow_d  = wrow_q;
    we_d    = 1'b0;
    row_d   = row_q;
    col_d   = col_q;
    wdata_d = wdata_q;
    cur_d   = cur_q;
`ifdef GD_SEQ_WDOG_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    case (state_q)
      LOAD: begin
        sh_d[bit_q] = S;
        if (bit_q == BIT_LAST) begin
          // Word complete: present it next cycle while the following word shifts in.
          bit_d   = '0;
          we_d    = 1'b1;
          wdata_d = sh_d;
          col_d   = wcol_q;
          row_d   = wrow_q;
          if (wcol_q == '0) begin
            wcol_d = cfg_feat_q;
            if (wrow_q == cfg_dp_q) state_d = WLAST;
            else                    wrow_d  = wrow_q + 1'b1;
          end else begin
            wcol_d = wcol_q - 1'b1;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      WLAST: begin
        row_d   = '0;
        cur_d   = '0;
        state_d = (cfg_ep_q == 8'd0) ? DONE : RD;
      end
      RD: state_d = ST;
      ST: begin
        state_d = WT;
`ifdef GD_SEQ_WDOG_EN
        wd_d = '0;
`endif
      end
      WT: begin
        if (upd_done) begin
          if (row_q < cfg_dp_q) begin
            row_d   = row_q + 1'b1;
            state_d = RD;
          end else if (({1'b0, cur_q} + 9'd1) < {1'b0, cfg_ep_q}) begin
            row_d   = '0;
            cur_d   = cur_q + 8'd1;
            state_d = RD;
          end else begin
            state_d = DONE;
          end
        end
`ifdef GD_SEQ_WDOG_EN
        else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  assign mem_we    = we_q;
  assign mem_row   = row_q;
  assign mem_col   = col_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = (state_q == RD);
  assign upd_start = (state_q == ST);
  assign done_     = (state_q == DONE);
  assign cur_epoch = cur_q;
  assign lr_q      = cfg_lr_q;
  assign feat_q    = cfg_feat_q;
`ifdef GD_SEQ_WDOG_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
